cardinal_nic: RTL and testbench
===============================

Name: cardinal_nic

Overview:
- Network interface controller between the pipelined CPU's NIC port and one node of the bidirectional ring router.
- CPU side: consumes nicEn, nicWrEn, nicAddr and nicDataOut from the CPU's EX/MEM stage, and returns read data to the CPU's nicDataIn.
- Router side: holds one 64-bit input channel buffer and one 64-bit output channel buffer, each with a full flag, using a ready/send handshake.
- All vectors are big-endian [0:N-1].

Parameters:
- DATA_WIDTH, 64, packet/register width.
- ADDR_WIDTH, 2, CPU register-select width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- addr  input  [0:1]  CPU register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- d_in  input  [0:63]  CPU write data.
- d_out  output  [0:63]  CPU read data.
- nicEn  input  1  CPU access enable.
- nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn.
- net_si  input  1  router sends a packet into the NIC.
- net_ri  output  1  NIC ready to accept a router packet.
- net_di  input  [0:63]  packet from router.
- net_so  output  1  NIC sends a packet to the router.
- net_ro  input  1  router ready to accept a packet.
- net_do  output  [0:63]  packet to router.
- net_polarity  input  1  router's current internal VC polarity.

Behaviour:
- Reset (reset=0, asynchronous): in_buf=0, in_full=0, out_buf=0, out_full=0. Resulting outputs: net_ri=1, net_so=0, net_do=0, d_out=0. Reset mid-transfer discards both buffers.
- Packet format: bit 0 = VC, bit 1 = direction, 8:15 = hop count, 16:63 = payload. The NIC does not modify packets.
- CPU read (nicEn=1, nicWrEn=0) is combinational, 0-cycle latency, because the CPU samples it in the same cycle:
  - 00 -> in_buf.
  - 01 -> {63'b0, in_full}.
  - 10 -> out_buf.
  - 11 -> {63'b0, out_full}.
  - d_out=0 whenever nicEn=0 or nicWrEn=1.
- Reading addr 00 with in_full=1 clears in_full at the next edge. Reading 00 while empty returns stale in_buf and has no side effect.
- CPU write (nicEn=1, nicWrEn=1):
  - addr 10 with out_full=0: out_buf<=d_in, out_full<=1 at the next edge.
  - addr 10 with out_full=1: write silently dropped.
  - Writes to 00, 01 or 11: ignored.
- Router input:
  - net_ri = ~in_full (combinational).
  - When net_si=1 and net_ri=1: in_buf<=net_di, in_full<=1.
  - net_si while net_ri=0: ignored.
- Router output:
  - net_do = out_buf.
  - net_so = out_full & net_ro & inject_ok (combinational).
  - When net_so=1, out_full<=0 at the edge; out_buf is retained.
  - inject_ok is defined under Optional Feature.
- Simultaneous events:
  - CPU write to 10 in the same cycle a send clears out_full: the write is dropped, because status is evaluated pre-edge. Output rate is at most one packet per 2 cycles.
  - CPU read of 00 clearing in_full in the same cycle as net_si: net_si is ignored (net_ri=0 that cycle); accepted the following cycle.
- No bypass paths; every buffer-to-buffer transfer is at least 1 cycle.

Optional Feature:
- Macro: NIC_POLARITY_CHECK_EN.
- Defined: inject_ok = (out_buf[0] == net_polarity). A packet waits with out_full=1 until the router polarity matches its VC bit.
- Undefined: inject_ok = 1; polarity ignored and net_polarity unused.

Test Plan:
- Reset then release: net_ri=1, net_so=0, d_out=0. CPU read of 01 and 11 -> 64'h0.
- CPU writes 64'h8000_0000_0000_00AA to addr 10 with net_ro=0. Read 11 -> 64'h1. Second write 64'h1234 dropped; read 10 -> 64'h8000_0000_0000_00AA.
- With out_full=1, out_buf[0]=1:
  - Set net_ro=1, net_polarity=0: with macro, net_so=0. Set net_polarity=1: net_so=1 for one cycle, net_do=64'h8000_0000_0000_00AA, then out_full=0.
  - Without macro: net_so=1 immediately on net_ro=1.
- Router pulses net_si with net_di=64'h0000_0000_DEAD_BEEF: next cycle net_ri=0 and read 01 -> 1. Read 00 -> 64'h0000_0000_DEAD_BEEF; following cycle net_ri=1 and read 01 -> 0.
- net_si held with net_di=64'h5 while in_full=1 and the CPU reads 00 in the same cycle: 64'h5 is not captured that cycle, is captured the next cycle, and the old data is returned by the read.
- Assert reset low mid-cycle while out_full=1 and in_full=1: both flags clear immediately (asynchronous), net_so=0 and net_ri=1 before the next clock edge.

Source files
------------

// File: rtl/cardinal_nic.sv
// Single-slot NIC between the CPU's NIC port and one ring-router node.
// Define NIC_POLARITY_CHECK_EN to hold outbound packets until the router VC polarity matches.
module cardinal_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:ADDR_WIDTH-1] addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    localparam logic [0:ADDR_WIDTH-1] ADDR_IN_BUF  = ADDR_WIDTH'(0);
    localparam logic [0:ADDR_WIDTH-1] ADDR_IN_STS  = ADDR_WIDTH'(1);
    localparam logic [0:ADDR_WIDTH-1] ADDR_OUT_BUF = ADDR_WIDTH'(2);
    localparam logic [0:ADDR_WIDTH-1] ADDR_OUT_STS = ADDR_WIDTH'(3);

    logic [0:DATA_WIDTH-1] in_buf_q,  in_buf_d;
    logic [0:DATA_WIDTH-1] out_buf_q, out_buf_d;
    logic                  in_full_q, in_full_d;
    logic                  out_full_q, out_full_d;

    logic rd_en, wr_en, in_push, in_pop, out_push, inject_ok;

`ifdef NIC_POLARITY_CHECK_EN
    assign inject_ok = (out_buf_q[0] == net_polarity);
`else
    logic unused_polarity;
    assign unused_polarity = net_polarity;
    assign inject_ok       = 1'b1;
`endif

    assign rd_en    = nicEn & ~nicWrEn;
    assign wr_en    = nicEn & nicWrEn;

    assign net_ri   = ~in_full_q;
    assign net_so   = out_full_q & net_ro & inject_ok;
    assign net_do   = out_buf_q;

    // All status decisions use pre-edge flags, so a pop/send never frees a slot for the same cycle.
    assign in_push  = net_si & ~in_full_q;
    assign in_pop   = rd_en & (addr == ADDR_IN_BUF) & in_full_q;
    assign out_push = wr_en & (addr == ADDR_OUT_BUF) & ~out_full_q;

    always_comb begin
        d_out = '0;
        if (rd_en) begin
            unique case (addr)
                ADDR_IN_BUF:  d_out = in_buf_q;
                ADDR_IN_STS:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full_q};
                ADDR_OUT_BUF: d_out = out_buf_q;
                ADDR_OUT_STS: d_out = {{(DATA_WIDTH-1){1'b0}}, out_full_q};
                default:      d_out = '0;
            endcase
        end
    end

    always_comb begin
        in_buf_d   = in_buf_q;
        in_full_d  = in_full_q;
        out_buf_d  = out_buf_q;
        out_full_d = out_full_q;

        if (in_push) begin
            in_buf_d  = net_di;
            in_full_d = 1'b1;
        end else if (in_pop) begin
            in_full_d = 1'b0;
        end

        // out_buf is kept after a send; only the full flag drops.
        if (out_push) begin
            out_buf_d  = d_in;
            out_full_d = 1'b1;
        end else if (net_so) begin
            out_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_buf_q   <= '0;
            in_full_q  <= 1'b0;
            out_buf_q  <= '0;
            out_full_q <= 1'b0;
        end else begin
            in_buf_q   <= in_buf_d;
            in_full_q  <= in_full_d;
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed bench for cardinal_nic: CPU register access, router handshakes and async reset.
module tb_cardinal_nic;

    logic        clk;
    logic        reset;
    logic [0:1]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;

    int checks = 0;
    int errors = 0;

    cardinal_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [1:0] a);
        nicEn   = 1'b1;
        nicWrEn = 1'b0;
        addr    = a;
        #1;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [63:0] v);
        nicEn   = 1'b1;
        nicWrEn = 1'b1;
        addr    = a;
        d_in    = v;
        #1;
    endtask

    task automatic cpu_idle();
        nicEn   = 1'b0;
        nicWrEn = 1'b0;
        addr    = 2'b00;
        #1;
    endtask

    initial begin
        reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;

        // Reset state
        #12;
        chk("rst_ri", 64'(net_ri), 64'h1);
        chk("rst_so", 64'(net_so), 64'h0);
        chk("rst_dout", d_out, 64'h0);
        chk("rst_do", net_do, 64'h0);
        reset = 1'b1;
        tick();
        cpu_read(2'b01); chk("in_sts_empty", d_out, 64'h0);
        cpu_read(2'b11); chk("out_sts_empty", d_out, 64'h0);

        // CPU write to output buffer, then a dropped second write
        cpu_write(2'b10, 64'h8000_0000_0000_00AA);
        chk("dout_on_write", d_out, 64'h0);
        tick();
        cpu_read(2'b11); chk("out_sts_full", d_out, 64'h1);
        chk("so_ro_low", 64'(net_so), 64'h0);
        cpu_write(2'b10, 64'h1234);
        tick();
        cpu_read(2'b10); chk("out_buf_kept", d_out, 64'h8000_0000_0000_00AA);
        chk("net_do_held", net_do, 64'h8000_0000_0000_00AA);

        // Injection, gated by polarity when the check is compiled in
        cpu_idle();
        net_polarity = 1'b0;
        net_ro = 1'b1;
        #1;
`ifdef NIC_POLARITY_CHECK_EN
        chk("so_pol_mismatch", 64'(net_so), 64'h0);
        tick();
        cpu_read(2'b11); chk("out_sts_waiting", d_out, 64'h1);
        cpu_idle();
        net_polarity = 1'b1;
        #1;
`endif
        chk("so_send", 64'(net_so), 64'h1);
        chk("do_send", net_do, 64'h8000_0000_0000_00AA);
        tick();
        chk("so_after_send", 64'(net_so), 64'h0);
        cpu_read(2'b11); chk("out_sts_sent", d_out, 64'h0);
        cpu_read(2'b10); chk("out_buf_retained", d_out, 64'h8000_0000_0000_00AA);
        net_ro = 1'b0;

        // Write during the cycle a send clears out_full is dropped
        cpu_write(2'b10, 64'h11);
        tick();
        net_polarity = 1'b0;
        net_ro = 1'b1;
        cpu_write(2'b10, 64'h22);
        chk("so_same_cycle", 64'(net_so), 64'h1);
        tick();
        net_ro = 1'b0;
        cpu_read(2'b11); chk("out_sts_race", d_out, 64'h0);
        cpu_read(2'b10); chk("out_buf_race", d_out, 64'h11);

        // Router input and CPU pop
        cpu_idle();
        net_si = 1'b1;
        net_di = 64'h0000_0000_DEAD_BEEF;
        #1;
        chk("ri_before_push", 64'(net_ri), 64'h1);
        tick();
        net_si = 1'b0;
        chk("ri_full", 64'(net_ri), 64'h0);
        cpu_read(2'b01); chk("in_sts_full", d_out, 64'h1);
        cpu_read(2'b00); chk("in_buf_read", d_out, 64'h0000_0000_DEAD_BEEF);
        tick();
        cpu_idle();
        chk("ri_after_pop", 64'(net_ri), 64'h1);
        cpu_read(2'b01); chk("in_sts_popped", d_out, 64'h0);
        cpu_read(2'b00); chk("in_buf_stale", d_out, 64'h0000_0000_DEAD_BEEF);
        tick();
        cpu_read(2'b01); chk("in_sts_stale_read", d_out, 64'h0);

        // Push while full coincides with a pop
        cpu_idle();
        net_si = 1'b1;
        net_di = 64'hAAA;
        tick();
        net_di = 64'h5;
        cpu_read(2'b00);
        chk("pop_old_data", d_out, 64'hAAA);
        chk("ri_during_pop", 64'(net_ri), 64'h0);
        tick();
        cpu_idle();
        chk("ri_next_cycle", 64'(net_ri), 64'h1);
        cpu_read(2'b00); chk("five_not_taken", d_out, 64'hAAA);
        tick();
        net_si = 1'b0;
        cpu_read(2'b01); chk("in_sts_five", d_out, 64'h1);
        cpu_read(2'b00); chk("in_buf_five", d_out, 64'h5);
        tick();

        // Asynchronous reset with both buffers full
        cpu_idle();
        net_si = 1'b1;
        net_di = 64'h7;
        tick();
        net_si = 1'b0;
        cpu_write(2'b10, 64'h33);
        tick();
        cpu_idle();
        chk("ri_pre_reset", 64'(net_ri), 64'h0);
        net_polarity = 1'b0;
        net_ro = 1'b1;
        #1;
        chk("so_pre_reset", 64'(net_so), 64'h1);
        reset = 1'b0;
        #1;
        chk("so_in_reset", 64'(net_so), 64'h0);
        chk("ri_in_reset", 64'(net_ri), 64'h1);
        chk("do_in_reset", net_do, 64'h0);
        cpu_read(2'b11); chk("out_sts_reset", d_out, 64'h0);
        cpu_read(2'b01); chk("in_sts_reset", d_out, 64'h0);
        cpu_read(2'b00); chk("in_buf_reset", d_out, 64'h0);
        cpu_idle();
        net_ro = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
